// File: rtl/pick_pair_alu_if.sv
// -----------------------------------------------------------------------------
// pick_pair_alu_if
// Groups the button-bank / display-side signals of pick_pair_alu.
//   master : drives enable, tick, buttons, op; observes the results
//   slave  : the ALU itself
// Signals:
//   enable   accept picks when high
//   tick     one-cycle debounce sample strobe
//   buttons  raw pushbuttons, active high, one per channel
//   op       00 add, 01 sub (A-B), 10 copy (A<=B), 11 swap
//   values   flattened channel values, channel i on [i*W +: W]
//   armed    operand A is held
//   sel_idx  index of operand A (valid while armed)
//   done     one-cycle write-back pulse
//   flag     carry / borrow of the last operation
//   timeout  one-cycle pulse when an armed selection expires
// -----------------------------------------------------------------------------
interface pick_pair_alu_if #(
    parameter int N = 10,
    parameter int W = 4
);
    logic             enable;
    logic             tick;
    logic [N-1:0]     buttons;
    logic [1:0]       op;
    logic [N*W-1:0]   values;
    logic             armed;
    logic [3:0]       sel_idx;
    logic             done;
    logic             flag;
    logic             timeout;

    modport master (
        output enable, tick, buttons, op,
        input  values, armed, sel_idx, done, flag, timeout
    );

    modport slave (
        input  enable, tick, buttons, op,
        output values, armed, sel_idx, done, flag, timeout
    );
endinterface

// File: rtl/pick_pair_alu.sv
// -----------------------------------------------------------------------------
// pick_pair_alu
// N channels of W-bit values, each with a debounced pick button. The first
// pick holds operand A, the second pick (a different channel) selects operand
// B and the operation; the result is written back to A's channel (both
// channels for swap). Picking A's channel again cancels the selection.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    pick_pair_alu_if.slave (enable, tick, buttons, op in;
//          values, armed, sel_idx, done, flag, timeout out)
//
// Optional feature: define PICK_PAIR_TIMEOUT_EN to abandon an armed
// selection after TIMEOUT_TICKS ticks without a second pick. Without it the
// timeout output is tied low and no tick counter exists.
// -----------------------------------------------------------------------------
module pick_pair_alu #(
    parameter int N             = 10,
    parameter int W             = 4,
    parameter int DB_SAMPLES    = 3,
    parameter int TIMEOUT_TICKS = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    pick_pair_alu_if.slave  bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_EXEC
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    pick;
    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic            cap_a, cap_b, do_wb;

    logic [W-1:0]    vals_q [N];
    logic [W-1:0]    a_q, b_q;
    logic [IW-1:0]   sel_q, idx_b_q;
    logic [1:0]      op_q;
    logic            done_q, flag_q;
    logic [W:0]      sum_w;
    logic [W-1:0]    diff_w;

`ifdef PICK_PAIR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0]   tcnt_q;
    logic            timeout_q;
    logic            tmo_hit;
    logic            to_pulse;
`endif

    // -------------------------------------------------------------------------
    // Per-channel debouncer: the level only changes once DB_SAMPLES
    // consecutive tick samples agree; a rising level yields a 1-clk pick.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_db
            logic [DB_SAMPLES-1:0] sr_q, sr_d;
            logic [DB_SAMPLES:0]   sr_cat;
            logic                  lvl_q, lvl_d, lvl_prev_q;

            assign sr_cat = {sr_q, bus.buttons[gi]};
            assign sr_d   = sr_cat[DB_SAMPLES-1:0];

            always_comb begin
                lvl_d = lvl_q;
                if (&sr_d)
                    lvl_d = 1'b1;
                else if (~|sr_d)
                    lvl_d = 1'b0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr_q       <= '0;
                    lvl_q      <= 1'b0;
                    lvl_prev_q <= 1'b0;
                end else begin
                    lvl_prev_q <= lvl_q;
                    if (bus.tick) begin
                        sr_q  <= sr_d;
                        lvl_q <= lvl_d;
                    end
                end
            end

            assign pick[gi] = lvl_q & ~lvl_prev_q;
        end
    endgenerate

    // Lowest index wins when several picks land in the same cycle.
    always_comb begin
        pick_any = |pick;
        pick_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i])
                pick_idx = IW'(i);
        end
    end

`ifdef PICK_PAIR_TIMEOUT_EN
    assign tmo_hit = (state_q == S_ARMED) && bus.tick &&
                     (tcnt_q == TW'(TIMEOUT_TICKS - 1));
`endif

    // -------------------------------------------------------------------------
    // Control FSM: next state and strobes.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cap_a   = 1'b0;
        cap_b   = 1'b0;
        do_wb   = 1'b0;
`ifdef PICK_PAIR_TIMEOUT_EN
        to_pulse = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.enable && pick_any) begin
                    state_d = S_ARMED;
                    cap_a   = 1'b1;
                end
            end
            S_ARMED: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (pick_any) begin
                    if (pick_idx == sel_q) begin
                        state_d = S_IDLE;       // same channel again: cancel
                    end else begin
                        state_d = S_EXEC;
                        cap_b   = 1'b1;
                    end
`ifdef PICK_PAIR_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_d  = S_IDLE;
                    to_pulse = 1'b1;
`endif
                end
            end
            S_EXEC: begin
                // Picks arriving here are dropped on purpose.
                state_d = S_IDLE;
                do_wb   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w = a_q - b_q;

    // -------------------------------------------------------------------------
    // State, operand capture and write-back.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            idx_b_q <= '0;
            op_q    <= 2'b00;
            done_q  <= 1'b0;
            flag_q  <= 1'b0;
            for (int i = 0; i < N; i++)
                vals_q[i] <= W'(i);
        end else begin
            state_q <= state_d;
            done_q  <= do_wb;
            if (cap_a) begin
                a_q   <= vals_q[pick_idx];
                sel_q <= pick_idx;
            end
            if (cap_b) begin
                b_q     <= vals_q[pick_idx];
                idx_b_q <= pick_idx;
                op_q    <= bus.op;
            end
            if (do_wb) begin
                case (op_q)
                    2'b00: begin
                        vals_q[sel_q] <= sum_w[W-1:0];
                        flag_q        <= sum_w[W];
                    end
                    2'b01: begin
                        vals_q[sel_q] <= diff_w;
                        flag_q        <= (a_q < b_q);
                    end
                    2'b10: begin
                        vals_q[sel_q] <= b_q;
                        flag_q        <= 1'b0;
                    end
                    default: begin
                        vals_q[sel_q]   <= b_q;
                        vals_q[idx_b_q] <= a_q;
                        flag_q          <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PICK_PAIR_TIMEOUT_EN
    // Counts ticks spent in ARMED; cleared whenever a new A is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_pulse;
            if (cap_a)
                tcnt_q <= '0;
            else if ((state_q == S_ARMED) && bus.tick)
                tcnt_q <= tcnt_q + 1'b1;
        end
    end
    assign bus.timeout = timeout_q;
`else
    localparam int unused_timeout_ticks = TIMEOUT_TICKS;
    assign bus.timeout = 1'b0;
`endif

    // A stays held through EXEC, so armed covers both ARMED and EXEC.
    assign bus.armed   = (state_q != S_IDLE);
    assign bus.sel_idx = 4'(sel_q);
    assign bus.done    = done_q;
    assign bus.flag    = flag_q;

    generate
        for (gi = 0; gi < N; gi++) begin : g_out
            assign bus.values[gi*W +: W] = vals_q[gi];
        end
    endgenerate

endmodule
